// File: rtl/usr_sw_pkg.sv
// usr_sw_pkg: shared definitions for the user DIP-switch debouncer.
//   sw_state_e : debouncer FSM encoding (ST_INIT=0, ST_RUN=1)
//   clog2()    : ceiling log2, used to size counters and queue pointers
//   evt_w()    : event record width, {prev, new}
package usr_sw_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } sw_state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r = r + 1;
    return r;
  endfunction

  function automatic int evt_w(input int sw_w);
    return 2 * sw_w;
  endfunction

endpackage

// File: rtl/usr_sw_evt_fifo.sv
// usr_sw_evt_fifo: small show-ahead event queue with drop-on-full.
//   clk, rstn   : clock, synchronous active-low reset (empties the queue)
//   push, din   : write request; ignored when full unless a pop is accepted
//                 in the same cycle
//   pop         : read request; ignored when empty
//   dout        : head entry, zero while empty
//   full, empty : occupancy flags (empty is registered)
module usr_sw_evt_fifo
  import usr_sw_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = clog2(DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]      wptr, rptr, wptr_n, rptr_n;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             empty_q, pop_ok, push_ok;

  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign pop_ok  = pop && !empty_q;
  // A pop in the same cycle frees the slot the push lands in.
  assign push_ok = push && (!full || pop_ok);
  assign wptr_n  = wptr + (AW+1)'(push_ok);
  assign rptr_n  = rptr + (AW+1)'(pop_ok);
  assign empty   = empty_q;
  assign dout    = empty_q ? '0 : mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wptr    <= '0;
      rptr    <= '0;
      empty_q <= 1'b1;
    end else begin
      wptr    <= wptr_n;
      rptr    <= rptr_n;
      empty_q <= (wptr_n == rptr_n);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/usr_sw_debounce.sv
// usr_sw_debounce: synchronise and debounce the user DIP switches, present a
// stable switch word and queue an event {prev,new} for every debounced change.
//   sys0_clk, sys0_rstn : clock, synchronous active-low reset
//   usr_sw_i            : raw asynchronous switch pins
//   sw_o, sw_valid      : debounced word, valid once first qualified
//   evt_valid/ready/data: show-ahead event queue head and pop handshake
//   evt_overflow,ovf_clr: sticky event-dropped flag and its clear
//   chg_cnt             : saturating count of generated events
module usr_sw_debounce
  import usr_sw_pkg::*;
#(
  parameter int SW_W         = 8,
  parameter int DEBOUNCE_CYC = 200000,
  parameter int EVT_DEPTH    = 4
) (
  input  logic              sys0_clk,
  input  logic              sys0_rstn,
  input  logic [SW_W-1:0]   usr_sw_i,
  output logic [SW_W-1:0]   sw_o,
  output logic              sw_valid,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [2*SW_W-1:0] evt_data,
  output logic              evt_overflow,
  input  logic              ovf_clr,
  output logic [15:0]       chg_cnt
);

  localparam int                CNT_W   = clog2(DEBOUNCE_CYC);
  localparam int                EW      = evt_w(SW_W);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEBOUNCE_CYC - 1);

  logic [SW_W-1:0] s1, s2, s3;
  logic [SW_W-1:0] qual, upd, sw_new;
  logic [EW-1:0]   evt_din;
  logic            chg, evt_empty, evt_full, pop_acc, drop;
  sw_state_e       state;

  // Two-flop synchroniser, plus s3 as the previous synchronised sample.
  always_ff @(posedge sys0_clk) begin
    if (!sys0_rstn) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s1 <= usr_sw_i;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // Per-bit stability counter; a bit is qualified once its synchronised
  // level has been steady long enough for the counter to saturate.
  for (genvar i = 0; i < SW_W; i++) begin : g_bit
    logic [CNT_W-1:0] cnt;
    always_ff @(posedge sys0_clk) begin
      if (!sys0_rstn)         cnt <= '0;
      else if (s2[i] != s3[i]) cnt <= '0;
      else if (cnt != CNT_MAX) cnt <= cnt + CNT_W'(1);
    end
    assign qual[i] = (cnt == CNT_MAX) && (s2[i] == s3[i]);
  end

  // In RUN, any qualified bit that disagrees with sw_o flips; all flips in
  // one cycle form a single event.
  assign upd     = (state == ST_RUN) ? (qual & (s2 ^ sw_o)) : '0;
  assign chg     = |upd;
  assign sw_new  = sw_o ^ upd;
  assign evt_din = {sw_o, sw_new};
  assign pop_acc = evt_valid && evt_ready;
  assign drop    = chg && evt_full && !pop_acc;

  always_ff @(posedge sys0_clk) begin
    if (!sys0_rstn) begin
      state    <= ST_INIT;
      sw_o     <= '0;
      sw_valid <= 1'b0;
    end else begin
      case (state)
        ST_INIT: begin
          // First load needs every bit qualified together; no event for it.
          if (&qual) begin
            sw_o     <= s2;
            sw_valid <= 1'b1;
            state    <= ST_RUN;
          end
        end
        ST_RUN:  sw_o <= sw_new;
        default: state <= ST_INIT;
      endcase
    end
  end

  always_ff @(posedge sys0_clk) begin
    if (!sys0_rstn) begin
      chg_cnt      <= '0;
      evt_overflow <= 1'b0;
    end else begin
      if (chg && (chg_cnt != 16'hFFFF)) chg_cnt <= chg_cnt + 16'd1;
      // A new drop wins over a simultaneous clear.
      if (drop)         evt_overflow <= 1'b1;
      else if (ovf_clr) evt_overflow <= 1'b0;
    end
  end

  usr_sw_evt_fifo #(
    .WIDTH (EW),
    .DEPTH (EVT_DEPTH)
  ) u_evt_fifo (
    .clk   (sys0_clk),
    .rstn  (sys0_rstn),
    .push  (chg),
    .din   (evt_din),
    .pop   (evt_ready),
    .dout  (evt_data),
    .full  (evt_full),
    .empty (evt_empty)
  );

  assign evt_valid = !evt_empty;

endmodule
